ifetch_seq: RTL and testbench

- Instruction-fetch sequencer in front of the program ROM (prgrom: word address on addra, 32-bit douta registered on the clock edge, 1-cycle read latency).
- Owns the PC and issues one ROM read per cycle.
- Absorbs the ROM latency with a 2-entry skid buffer and hands instructions to decode over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing in-flight and buffered words.

---
 rtl/ifetch_seq_if.sv | 26 ++
 rtl/ifetch_seq.sv | 95 +++++++++
 tb/tb_ifetch_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_seq_if.sv
// Fetch-side bundle: ROM port, redirect input and the decode valid/ready handshake.
// The master side is the sequencer; the slave side is ROM + decode + execute.
interface ifetch_seq_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              fetch_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_dout;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst_out;
   logic [31:0]       inst_pc;
   logic              busy;

   modport master (
      input  fetch_en, rom_dout, redirect_valid, redirect_pc, inst_ready,
      output rom_addr, inst_valid, inst_out, inst_pc, busy
   );

   modport slave (
      output fetch_en, rom_dout, redirect_valid, redirect_pc, inst_ready,
      input  rom_addr, inst_valid, inst_out, inst_pc, busy
   );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one ROM read per cycle, absorbs the
// 1-cycle ROM latency in a 2-entry skid buffer and flushes everything on a redirect.
module ifetch_seq #(
   parameter int unsigned ADDR_W   = 14,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clock,
   input logic          reset,
   ifetch_seq_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] ent_pc_q [2];
   logic [31:0] ent_pc_d [2];
   logic [31:0] ent_word_q [2];
   logic [31:0] ent_word_d [2];

   logic [31:0] target;
   logic        xfer;
   logic        push;
   logic        issue;
   logic        wr_idx;

   assign target         = bus.redirect_pc & ~32'h3;
   assign bus.inst_valid = (cnt_q != 2'd0) && !bus.redirect_valid;
   assign bus.inst_out   = ent_word_q[0];
   assign bus.inst_pc    = ent_pc_q[0];
   assign bus.busy       = inflight_q || (cnt_q != 2'd0);
   assign bus.rom_addr   = bus.redirect_valid ? target[ADDR_W+1:2] : pc_q[ADDR_W+1:2];

   assign xfer  = bus.inst_valid && bus.inst_ready;
   // A redirect discards the word landing this cycle.
   assign push  = inflight_q && !bus.redirect_valid;
   // Buffer slots plus the in-flight read never exceed two; a pop frees one slot now.
   assign issue = bus.fetch_en &&
                  (bus.redirect_valid || xfer || ((cnt_q + {1'b0, inflight_q}) < 2'd2));

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (bus.redirect_valid) begin
         pc_d = bus.fetch_en ? target + 32'd4 : target;
         if (issue) inflight_pc_d = target;
      end else if (issue) begin
         inflight_pc_d = pc_q;
         pc_d          = pc_q + 32'd4;
      end
   end

   // Shift-style FIFO: entry 0 is always the head.
   always_comb begin
      cnt_d      = cnt_q;
      ent_pc_d   = ent_pc_q;
      ent_word_d = ent_word_q;
      wr_idx     = ((cnt_q - {1'b0, xfer}) == 2'd1);
      if (bus.redirect_valid) begin
         cnt_d = 2'd0;
      end else begin
         if (xfer) begin
            ent_pc_d[0]   = ent_pc_q[1];
            ent_word_d[0] = ent_word_q[1];
         end
         if (push) begin
            ent_pc_d[wr_idx]   = inflight_pc_q;
            ent_word_d[wr_idx] = bus.rom_dout;
         end
         cnt_d = cnt_q + {1'b0, push} - {1'b0, xfer};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'd0;
         cnt_q         <= 2'd0;
         ent_pc_q[0]   <= 32'd0;
         ent_pc_q[1]   <= 32'd0;
         ent_word_q[0] <= 32'd0;
         ent_word_q[1] <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         cnt_q         <= cnt_d;
         ent_pc_q      <= ent_pc_d;
         ent_word_q    <= ent_word_d;
      end
   end

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq; the ROM model returns 32'hA000_0000 + word address.
module tb_ifetch_seq;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   ifetch_seq_if #(.ADDR_W(14)) bus ();

   ifetch_seq #(.ADDR_W(14), .RESET_PC(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) bus.rom_dout <= 32'hA000_0000 + 32'(bus.rom_addr);

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reset low for 2 ns just after an edge; the following edge is the first live one.
   task automatic restart(input logic ready);
      @(posedge clock);
      #1;
      reset              = 1'b0;
      bus.fetch_en       = 1'b1;
      bus.inst_ready     = ready;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      #2 reset = 1'b1;
   endtask

   task automatic test_reset();
      reset              = 1'b0;
      bus.fetch_en       = 1'b0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      #1;
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.inst_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.inst_out); end
      checks++; if (bus.inst_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.inst_pc); end
      checks++; if (bus.rom_addr !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.rom_addr); end
   endtask

   task automatic test_stream();
      restart(1'b1);
      tick();
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1_valid: got %b want 0", bus.inst_valid); end
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.inst_valid); end
         checks++; if (bus.inst_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.inst_pc, 32'(4 * k)); end
         checks++; if (bus.inst_out !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL stream_out[%0d]: got %h want %h", k, bus.inst_out, 32'hA000_0000 + 32'(k)); end
         checks++; if (bus.rom_addr !== 14'(k + 2)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, bus.rom_addr, 14'(k + 2)); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [4];
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
      restart(1'b1);
      tick();
      tick();
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.inst_valid); end
         checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL bp_hold_pc[%0d]: got %h want 0", i, bus.inst_pc); end
         checks++; if (bus.rom_addr !== 14'h2) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 2", i, bus.rom_addr); end
      end
      bus.inst_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[i]) begin errors++; $display("FAIL bp_release[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, bus.inst_valid, bus.inst_pc, exp_pc[i]); end
      end
   endtask

   task automatic test_redirect();
      restart(1'b1);
      tick();
      tick();
      bus.inst_ready = 1'b0;
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0043;
      #1;
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_mask: got %b want 0", bus.inst_valid); end
      checks++; if (bus.rom_addr !== 14'h10) begin errors++; $display("FAIL redir_addr: got %h want 10", bus.rom_addr); end
      tick();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b1;
      #1;
      checks++; if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL redir_flush: got valid=%b busy=%b want valid=0 busy=1", bus.inst_valid, bus.busy); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_out !== 32'hA000_0010) begin errors++; $display("FAIL redir_first: got valid=%b pc=%h out=%h want 1/40/a0000010", bus.inst_valid, bus.inst_pc, bus.inst_out); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h44 || bus.inst_out !== 32'hA000_0011) begin errors++; $display("FAIL redir_second: got valid=%b pc=%h out=%h want 1/44/a0000011", bus.inst_valid, bus.inst_pc, bus.inst_out); end
   endtask

   task automatic test_wrap();
      restart(1'b1);
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_FFF8;
      #1;
      checks++; if (bus.rom_addr !== 14'h3FFE) begin errors++; $display("FAIL wrap_addr0: got %h want 3ffe", bus.rom_addr); end
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      checks++; if (bus.rom_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_addr1: got %h want 3fff", bus.rom_addr); end
      tick();
      checks++; if (bus.rom_addr !== 14'h0000) begin errors++; $display("FAIL wrap_addr2: got %h want 0", bus.rom_addr); end
      checks++; if (bus.inst_pc !== 32'h0000_FFF8 || bus.inst_out !== 32'hA000_3FFE) begin errors++; $display("FAIL wrap_inst0: got pc=%h out=%h want fff8/a0003ffe", bus.inst_pc, bus.inst_out); end
      tick();
      checks++; if (bus.inst_pc !== 32'h0000_FFFC || bus.inst_out !== 32'hA000_3FFF) begin errors++; $display("FAIL wrap_inst1: got pc=%h out=%h want fffc/a0003fff", bus.inst_pc, bus.inst_out); end
      tick();
      checks++; if (bus.inst_pc !== 32'h0001_0000 || bus.inst_out !== 32'hA000_0000) begin errors++; $display("FAIL wrap_inst2: got pc=%h out=%h want 10000/a0000000", bus.inst_pc, bus.inst_out); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFE;
      #1;
      checks++; if (bus.rom_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap32_addr0: got %h want 3fff", bus.rom_addr); end
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      checks++; if (bus.rom_addr !== 14'h0000) begin errors++; $display("FAIL wrap32_addr1: got %h want 0", bus.rom_addr); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap32_inst0: got valid=%b pc=%h want 1/fffffffc", bus.inst_valid, bus.inst_pc); end
      tick();
      checks++; if (bus.inst_pc !== 32'h0 || bus.inst_out !== 32'hA000_0000) begin errors++; $display("FAIL wrap32_inst1: got pc=%h out=%h want 0/a0000000", bus.inst_pc, bus.inst_out); end
   endtask

   task automatic test_drain();
      restart(1'b1);
      tick();
      tick();
      bus.fetch_en = 1'b0;
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) begin errors++; $display("FAIL drain_inflight: got valid=%b pc=%h want 1/4", bus.inst_valid, bus.inst_pc); end
      tick();
      checks++; if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid=%b busy=%b want 0/0", bus.inst_valid, bus.busy); end
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.rom_addr !== 14'h2) begin errors++; $display("FAIL drain_idle: got busy=%b addr=%h want 0/2", bus.busy, bus.rom_addr); end
      bus.fetch_en = 1'b1;
      tick();
      checks++; if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL drain_resume: got valid=%b busy=%b want 0/1", bus.inst_valid, bus.busy); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8) begin errors++; $display("FAIL drain_next0: got valid=%b pc=%h want 1/8", bus.inst_valid, bus.inst_pc); end
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hC) begin errors++; $display("FAIL drain_next1: got valid=%b pc=%h want 1/c", bus.inst_valid, bus.inst_pc); end
   endtask

   task automatic test_reset_mid();
      restart(1'b1);
      tick();
      tick();
      bus.inst_ready = 1'b0;
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre: got valid=%b busy=%b want 1/1", bus.inst_valid, bus.busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.inst_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_async: got valid=%b busy=%b want 0/0", bus.inst_valid, bus.busy); end
      checks++; if (bus.inst_pc !== 32'h0 || bus.inst_out !== 32'h0 || bus.rom_addr !== 14'h0) begin errors++; $display("FAIL rmid_clear: got pc=%h out=%h addr=%h want 0/0/0", bus.inst_pc, bus.inst_out, bus.rom_addr); end
      bus.inst_ready = 1'b1;
      #1 reset = 1'b1;
      tick();
      tick();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_out !== 32'hA000_0000) begin errors++; $display("FAIL rmid_restart: got valid=%b pc=%h out=%h want 1/0/a0000000", bus.inst_valid, bus.inst_pc, bus.inst_out); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_drain();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
